imem_loader: RTL and testbench

Byte-stream program loader that writes instruction memory from an external host (UART/debug bridge) at boot or on demand. It parses a framed stream (magic, base address, length, payload, checksum) into a byte-wide write port on the instruction memory and holds the core in reset while a load is in progress. It sits between the host link and the instruction memory's write side, and gates the core's reset.

---
 rtl/imem_loader.sv | 173 +++++++++++++++++
 tb/tb_imem_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Framed byte-stream loader: parses magic/base/len/payload/csum into byte writes
// on the instruction memory and holds the core in reset while a load is pending.
//
// state | meaning
// IDLE  | waiting for 0xA5 magic, other bytes dropped
// ADDR  | collecting 4 base-address bytes, little-endian
// LEN   | collecting 4 length bytes, range check on the last one
// DATA  | writing payload bytes, one per accepted byte
// CSUM  | checking the checksum byte
// DONE  | frame loaded and verified, core released
// ERR   | frame rejected (range or checksum), core held
module imem_loader #(
  parameter int unsigned MEM_BYTES = 32'd4096,
  parameter bit          BOOT_HOLD = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  s_data_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  output logic        we_o,
  output logic [31:0] wa_o,
  output logic [7:0]  wd_o,
  output logic [31:0] entry_o,
  output logic        core_rst_no,
  output logic        done_o,
  output logic        err_o
);

  localparam logic [7:0]  MAGIC     = 8'hA5;
  localparam logic [32:0] MEM_LIMIT = {1'b0, MEM_BYTES};

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_LEN  = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_CSUM = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;
  localparam logic [2:0] ST_ERR  = 3'd6;

  logic [2:0]  r_state;
  logic [1:0]  r_idx;
  logic [31:0] r_base;
  logic [31:0] r_len;
  logic [31:0] r_addr;
  logic [31:0] r_rem;
  logic [7:0]  r_sum;
  logic        r_we;
  logic [31:0] r_wa;
  logic [7:0]  r_wd;
  logic [31:0] r_entry;
  logic        r_done;
  logic        r_err;
  logic        r_core_rst_n;

  logic        w_ready;
  logic        w_xfer;
  logic        w_magic;
  logic        w_last_idx;
  logic [31:0] w_base_full;
  logic [31:0] w_len_full;
  logic [32:0] w_end;
  logic        w_range_bad;
  logic [7:0]  w_csum;

  always_comb begin
    w_ready = 1'b1;
    case (r_state)
      ST_IDLE, ST_ADDR, ST_LEN, ST_DATA,
      ST_CSUM, ST_DONE, ST_ERR: w_ready = 1'b1;
      default:                  w_ready = 1'b1;
    endcase
  end

  assign w_xfer      = s_valid_i & w_ready;
  assign w_magic     = (s_data_i == MAGIC);
  assign w_last_idx  = (r_idx == 2'd3);
  assign w_base_full = {s_data_i, r_base[31:8]};
  assign w_len_full  = {s_data_i, r_len[31:8]};
  // 33-bit sum so a base near 4 GiB cannot wrap past the range check
  assign w_end       = {1'b0, r_base} + {1'b0, w_len_full};
  assign w_range_bad = (w_end > MEM_LIMIT);
  assign w_csum      = r_sum + s_data_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ST_IDLE;
      r_idx        <= 2'd0;
      r_base       <= 32'd0;
      r_len        <= 32'd0;
      r_addr       <= 32'd0;
      r_rem        <= 32'd0;
      r_sum        <= 8'd0;
      r_we         <= 1'b0;
      r_wa         <= 32'd0;
      r_wd         <= 8'd0;
      r_entry      <= 32'd0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_core_rst_n <= !BOOT_HOLD;
    end else begin
      r_we <= 1'b0;
      if (w_xfer) begin
        case (r_state)
          ST_IDLE, ST_DONE, ST_ERR: begin
            if (w_magic) begin
              r_state      <= ST_ADDR;
              r_idx        <= 2'd0;
              r_done       <= 1'b0;
              r_err        <= 1'b0;
              r_core_rst_n <= 1'b0;
            end
          end
          ST_ADDR: begin
            r_base <= w_base_full;
            r_idx  <= r_idx + 2'd1;
            if (w_last_idx) begin
              r_entry <= w_base_full;
              r_state <= ST_LEN;
            end
          end
          ST_LEN: begin
            r_len <= w_len_full;
            r_idx <= r_idx + 2'd1;
            if (w_last_idx) begin
              r_addr <= r_base;
              r_rem  <= w_len_full;
              r_sum  <= 8'd0;
              if (w_range_bad) begin
                r_err   <= 1'b1;
                r_state <= ST_ERR;
              end else if (w_len_full == 32'd0) begin
                r_state <= ST_CSUM;
              end else begin
                r_state <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            r_we   <= 1'b1;
            r_wa   <= r_addr;
            r_wd   <= s_data_i;
            r_addr <= r_addr + 32'd1;
            r_rem  <= r_rem - 32'd1;
            r_sum  <= w_csum;
            if (r_rem == 32'd1) r_state <= ST_CSUM;
          end
          ST_CSUM: begin
            if (w_csum == 8'd0) begin
              r_done       <= 1'b1;
              r_core_rst_n <= 1'b1;
              r_state      <= ST_DONE;
            end else begin
              r_err   <= 1'b1;
              r_state <= ST_ERR;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign s_ready_o   = w_ready;
  assign we_o        = r_we;
  assign wa_o        = r_wa;
  assign wd_o        = r_wd;
  assign entry_o     = r_entry;
  assign core_rst_no = r_core_rst_n;
  assign done_o      = r_done;
  assign err_o       = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad/range frames, noise with gaps,
// and an asynchronous reset in the middle of a payload.
module tb_imem_loader;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  s_data_i = 8'h00;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic        we_o;
  logic [31:0] wa_o;
  logic [7:0]  wd_o;
  logic [31:0] entry_o;
  logic        core_rst_no;
  logic        done_o;
  logic        err_o;

  int passed = 0;
  int total  = 0;
  int we_cnt = 0;
  int we_base;

  imem_loader dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .s_data_i    (s_data_i),
    .s_valid_i   (s_valid_i),
    .s_ready_o   (s_ready_o),
    .we_o        (we_o),
    .wa_o        (wa_o),
    .wd_o        (wd_o),
    .entry_o     (entry_o),
    .core_rst_no (core_rst_no),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (we_o) we_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // drive one byte for exactly one clock; returns 1 ns after the accepting edge
  task automatic send(input logic [7:0] b);
    s_data_i  = b;
    s_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    s_valid_i = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    send(b);
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_hdr(input logic [31:0] base, input logic [31:0] len);
    send(8'hA5);
    for (int i = 0; i < 4; i++) send(8'(base >> (8 * i)));
    for (int i = 0; i < 4; i++) send(8'(len >> (8 * i)));
  endtask

  task automatic send_wr(input string tag, input logic [7:0] b, input logic [31:0] addr);
    send(b);
    check({tag, "_we"}, {31'd0, we_o}, 32'd1);
    check({tag, "_wa"}, wa_o, addr);
    check({tag, "_wd"}, {24'd0, wd_o}, {24'd0, b});
  endtask

  task automatic good_frame(input string tag);
    send_hdr(32'h10, 32'd4);
    check({tag, "_hold"}, {31'd0, core_rst_no}, 32'd0);
    send_wr({tag, "_w0"}, 8'h13, 32'h10);
    send_wr({tag, "_w1"}, 8'h05, 32'h11);
    send_wr({tag, "_w2"}, 8'h00, 32'h12);
    send_wr({tag, "_w3"}, 8'h00, 32'h13);
    send(8'hE8);
    check({tag, "_we_after"}, {31'd0, we_o}, 32'd0);
    check({tag, "_done"}, {31'd0, done_o}, 32'd1);
    check({tag, "_err"}, {31'd0, err_o}, 32'd0);
    check({tag, "_core"}, {31'd0, core_rst_no}, 32'd1);
    check({tag, "_entry"}, entry_o, 32'h10);
  endtask

  initial begin
    // reset
    #3;
    check("rst_ready", {31'd0, s_ready_o}, 32'd1);
    check("rst_core", {31'd0, core_rst_no}, 32'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("rst_we", {31'd0, we_o}, 32'd0);
    check("rst_wa", wa_o, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_entry", entry_o, 32'd0);
    check("rst_core_after", {31'd0, core_rst_no}, 32'd0);
    check("rst_ready_after", {31'd0, s_ready_o}, 32'd1);

    good_frame("good");

    // bad checksum: A5 out of DONE clears done and re-holds the core
    send(8'hA5);
    check("bad_done_clr", {31'd0, done_o}, 32'd0);
    check("bad_core_hold", {31'd0, core_rst_no}, 32'd0);
    for (int i = 0; i < 4; i++) send(i == 0 ? 8'h10 : 8'h00);
    send(8'h04); send(8'h00); send(8'h00); send(8'h00);
    send_wr("bad_w0", 8'h13, 32'h10);
    send_wr("bad_w1", 8'h05, 32'h11);
    send_wr("bad_w2", 8'h00, 32'h12);
    send_wr("bad_w3", 8'h00, 32'h13);
    send(8'h00);
    check("bad_err", {31'd0, err_o}, 32'd1);
    check("bad_done", {31'd0, done_o}, 32'd0);
    check("bad_core", {31'd0, core_rst_no}, 32'd0);

    // range error: base = 4094, len = 4 -> end 4098 > 4096
    send(8'hA5);
    check("rng_err_clr", {31'd0, err_o}, 32'd0);
    send(8'hFE); send(8'h0F); send(8'h00); send(8'h00);
    send(8'h04); send(8'h00); send(8'h00);
    check("rng_not_yet", {31'd0, err_o}, 32'd0);
    send(8'h00);
    check("rng_err", {31'd0, err_o}, 32'd1);
    check("rng_entry", entry_o, 32'h0000_0FFE);
    we_base = we_cnt;
    send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'hF6);
    check("rng_no_we", 32'(we_cnt - we_base), 32'd0);
    check("rng_err_hold", {31'd0, err_o}, 32'd1);
    check("rng_core", {31'd0, core_rst_no}, 32'd0);

    // exact-fit boundary: base = 4092, len = 4 -> end 4096 is legal
    send_hdr(32'd4092, 32'd4);
    check("fit_no_err", {31'd0, err_o}, 32'd0);
    send_wr("fit_w0", 8'h01, 32'd4092);
    send_wr("fit_w1", 8'h02, 32'd4093);
    send_wr("fit_w2", 8'h03, 32'd4094);
    send_wr("fit_w3", 8'h04, 32'd4095);
    send(8'hF6);
    check("fit_done", {31'd0, done_o}, 32'd1);

    // noise with gaps, then a zero-length frame
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    send(8'h01);
    check("pre_err", {31'd0, err_o}, 32'd1);
    we_base = we_cnt;
    send_gap(8'h00);
    send_gap(8'hFF);
    check("noise_err_hold", {31'd0, err_o}, 32'd1);
    check("noise_done", {31'd0, done_o}, 32'd0);
    send_gap(8'hA5);
    send_gap(8'h20); send_gap(8'h00); send_gap(8'h00); send_gap(8'h00);
    send_gap(8'h00); send_gap(8'h00); send_gap(8'h00); send_gap(8'h00);
    check("z_hold", {31'd0, core_rst_no}, 32'd0);
    send_gap(8'h00);
    check("z_done", {31'd0, done_o}, 32'd1);
    check("z_err", {31'd0, err_o}, 32'd0);
    check("z_core", {31'd0, core_rst_no}, 32'd1);
    check("z_entry", entry_o, 32'h20);
    check("z_no_we", 32'(we_cnt - we_base), 32'd0);

    // reset in the middle of a payload
    send_hdr(32'h40, 32'd4);
    send_wr("mid_w0", 8'h11, 32'h40);
    send_wr("mid_w1", 8'h22, 32'h41);
    rst_ni = 1'b0;
    #1;
    check("mid_we", {31'd0, we_o}, 32'd0);
    check("mid_wa", wa_o, 32'd0);
    check("mid_entry", entry_o, 32'd0);
    check("mid_core", {31'd0, core_rst_no}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("mid_done", {31'd0, done_o}, 32'd0);
    good_frame("again");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed run still active expected finished");
    $fatal(1, "timeout");
  end

endmodule
